m_unit: RTL and testbench
=========================

# m_unit

Multi-cycle RV32M multiply/divide unit beside the execute stage. Accepts an M-extension instruction with its forwarded operands from execute, computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, and returns result, destination and write-enable. Execute muxes these onto its writeback path on `m_unit_ready`. `m_unit_busy` stalls the front of the pipeline while an operation is in flight.

## Interface
- No parameters; width fixed at 32 (XLEN).
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- m_start  in  1  execute holds a valid M-type instruction (opcode R-type, func7 = 0000001)
- pipeline_flush  in  1  execute-stage instruction is being squashed
- op1  in  32  forwarded rs1 value (execute `op1_selected`)
- op2  in  32  forwarded rs2 value (execute `op2_selected`)
- func3  in  3  M operation select
- rd  in  5  destination register
- wr_en  in  1  register-file write enable of the instruction
- m_unit_result  out  32  final result, valid while `m_unit_ready`
- m_unit_ready  out  1  one-cycle result strobe
- m_unit_dest  out  5  destination register, valid while `m_unit_ready`
- m_unit_wr  out  1  write enable, valid while `m_unit_ready`
- m_unit_busy  out  1  unit not IDLE; upstream must hold

## Operation
- States: IDLE, ITER, DONE.
- IDLE: accept on edge when `m_start & ~pipeline_flush`. Latch rd, wr_en, func3, operand signs, operand magnitudes.
  - MULH/DIV/REM: both operands signed. MULHSU: op1 signed only. Others unsigned.
  - Divide special cases go straight to DONE.
  - Otherwise clear the 6-bit iteration counter and go to ITER.
- `m_start` with `pipeline_flush`: ignored, stay IDLE.
- `m_start` outside IDLE: ignored.
- ITER, multiply: radix-2 shift-add of magnitudes into 64-bit product, 32 iterations.
- ITER, divide: restoring division of magnitudes, 32 iterations, 32-bit quotient and remainder.
- After the 32nd iteration: go to DONE and apply sign fix-up.
  - Product: negated if signs differ.
  - Quotient: negated if signs differ.
  - Remainder: takes dividend sign.
- Result select:
  - MUL: product[31:0].
  - MULH/MULHSU/MULHU: product[63:32].
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- Special cases:
  - Divide by zero: quotient = FFFFFFFF, remainder = op1.
  - Signed overflow (80000000 / FFFFFFFF): quotient = 80000000, remainder = 0.
- DONE: `m_unit_ready` = 1 for exactly one cycle, then IDLE.
- `pipeline_flush` after acceptance does not abort. The M instruction is older than any squashing branch and always completes.

## Timing
- Cycle 0 = `m_start` sampled high in IDLE.
- Iterative ops:
  - ITER in cycles 1–32.
  - DONE, `m_unit_ready` = 1 in cycle 33.
  - IDLE in cycle 34; a new start can be accepted in cycle 34.
- Divide special cases: DONE in cycle 1.
- `m_unit_busy` = 1 from cycle 1 through the DONE cycle inclusive.
- All outputs registered; no combinational path from inputs to outputs.
- Reset (any time, including mid-operation): state IDLE, counter 0, all outputs 0, in-flight operation discarded.

## Configuration
- `M_UNIT_FAST_MUL_EN` defined: all four multiplies use a single 33×33 signed combinational multiply on sign-extended operands, registered at acceptance. DONE in cycle 1, the same as divide special cases. Division stays iterative.
- Undefined: multiplies use the iterative path (DONE in cycle 33). No hardware multiplier is inferred.

## Structure
- Shared defines header holds:
  - M func3 encodings `M_MUL` 000, `M_MULH` 001, `M_MULHSU` 010, `M_MULHU` 011, `M_DIV` 100, `M_DIVU` 101, `M_REM` 110, `M_REMU` 111.
  - State encodings.
- Sub-module `m_unit_divider`: iterative restoring divider core (start, magnitudes in, quotient/remainder out, done). The FSM, multiplier, sign handling and output registers stay in `m_unit`.

## Test plan
- MUL 7 × FFFFFFFD (−3), rd = 5 -> ready in cycle 33, result FFFFFFEB, dest 5, busy cycles 1–33.
- MULH 80000000 × 80000000 -> 40000000; MULHSU FFFFFFFF × FFFFFFFF -> FFFFFFFF; MULHU FFFFFFFF × FFFFFFFF -> FFFFFFFE.
- DIV FFFFFFF9 (−7) / 2 -> FFFFFFFD; REM -> FFFFFFFF; DIVU 7 / 2 -> 3; REMU -> 1. All ready in cycle 33.
- DIVU 1234 / 0 -> FFFFFFFF in cycle 1; REM 1234 / 0 -> 1234. DIV 80000000 / FFFFFFFF -> 80000000; REM -> 0.
- `m_start` with `pipeline_flush` -> never busy, no ready. `pipeline_flush` in cycle 10 of a DIV -> still completes in cycle 33.
- `rst_n` low in cycle 15 of a MUL -> outputs 0 immediately, IDLE. New start after release -> correct result with no stale ready.

Source files
------------

// File: rtl/m_unit_pkg.sv
// rtl/m_unit_pkg.sv - shared encodings for the RV32M multiply/divide unit
package m_unit_pkg;

  // M-extension func3 encodings
  localparam logic [2:0] M_MUL    = 3'b000;
  localparam logic [2:0] M_MULH   = 3'b001;
  localparam logic [2:0] M_MULHSU = 3'b010;
  localparam logic [2:0] M_MULHU  = 3'b011;
  localparam logic [2:0] M_DIV    = 3'b100;
  localparam logic [2:0] M_DIVU   = 3'b101;
  localparam logic [2:0] M_REM    = 3'b110;
  localparam logic [2:0] M_REMU   = 3'b111;

  // Control FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/m_unit_divider.sv
// rtl/m_unit_divider.sv - 32-step restoring divider core on unsigned magnitudes
module m_unit_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done
);

  logic        run_q, run_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic [32:0] shifted;
  logic [32:0] trial;

  // One restoring step; outputs are this step's results so the caller can
  // register the final values on the same edge as the 32nd step.
  always_comb begin
    shifted = {rem_q, quo_q[31]};
    trial   = shifted - {1'b0, dvs_q};
    if (trial[32]) begin
      remainder = shifted[31:0];
      quotient  = {quo_q[30:0], 1'b0};
    end else begin
      remainder = trial[31:0];
      quotient  = {quo_q[30:0], 1'b1};
    end
    done = run_q & (cnt_q == 5'd31);
  end

  // Load on start, then advance one quotient bit per cycle
  always_comb begin
    run_d = run_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    if (start) begin
      run_d = 1'b1;
      cnt_d = 5'd0;
      quo_d = dividend;
      rem_d = 32'd0;
      dvs_d = divisor;
    end else if (run_q) begin
      quo_d = quotient;
      rem_d = remainder;
      cnt_d = cnt_q + 5'd1;
      if (done) run_d = 1'b0;
    end
  end

  // Divider state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      cnt_q <= 5'd0;
      quo_q <= 32'd0;
      rem_q <= 32'd0;
      dvs_q <= 32'd0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  end

endmodule

// File: rtl/m_unit.sv
// rtl/m_unit.sv - RV32M multiply/divide unit; M_UNIT_FAST_MUL_EN selects single-cycle multiply
import m_unit_pkg::*;

module m_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m_start,
  input  logic        pipeline_flush,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [2:0]  func3,
  input  logic [4:0]  rd,
  input  logic        wr_en,
  output logic [31:0] m_unit_result,
  output logic        m_unit_ready,
  output logic [4:0]  m_unit_dest,
  output logic        m_unit_wr,
  output logic        m_unit_busy
);

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  func3_q, func3_d;
  logic [4:0]  rd_q, rd_d;
  logic        wr_en_q, wr_en_d;
  logic        res_neg_q, res_neg_d;
  logic        a_neg_q, a_neg_d;
  logic [31:0] mcand_q, mcand_d;
  logic [63:0] prod_q, prod_d;
  logic [31:0] result_q, result_d;
  logic        ready_q, ready_d;
  logic [4:0]  dest_q, dest_d;
  logic        wr_q, wr_d;
  logic        busy_q, busy_d;

  logic        accept, signed_a, signed_b, a_neg, b_neg;
  logic        div_zero, div_ovf, special, div_start, div_done, iter_last;
  logic [31:0] a_mag, b_mag, special_res, div_quo, div_rem;
  logic [32:0] add_sum;
  logic [63:0] prod_step, prod_fix;
  logic [31:0] quo_fix, rem_fix, final_res;

  // Operand decode at acceptance: signedness, magnitudes, divide special cases
  always_comb begin
    accept   = (state_q == S_IDLE) & m_start & ~pipeline_flush;
    signed_a = (func3 == M_MULH) | (func3 == M_MULHSU) | (func3 == M_DIV) | (func3 == M_REM);
    signed_b = (func3 == M_MULH) | (func3 == M_DIV) | (func3 == M_REM);
    a_neg    = signed_a & op1[31];
    b_neg    = signed_b & op2[31];
    a_mag    = a_neg ? (32'd0 - op1) : op1;
    b_mag    = b_neg ? (32'd0 - op2) : op2;
    div_zero = (op2 == 32'd0);
    div_ovf  = ((func3 == M_DIV) | (func3 == M_REM)) & (op1 == 32'h8000_0000) & (op2 == 32'hFFFF_FFFF);
    special  = func3[2] & (div_zero | div_ovf);
    if (div_zero) special_res = func3[1] ? op1 : 32'hFFFF_FFFF;
    else          special_res = func3[1] ? 32'd0 : 32'h8000_0000;
  end

`ifdef M_UNIT_FAST_MUL_EN
  logic signed [63:0] fast_a, fast_b, fast_prod;
  logic        [31:0] fast_res;

  // 33x33 signed multiply on sign-extended operands, low 64 bits kept
  always_comb begin
    fast_a    = {{32{a_neg}}, op1};
    fast_b    = {{32{b_neg}}, op2};
    fast_prod = fast_a * fast_b;
    fast_res  = (func3 == M_MUL) ? fast_prod[31:0] : fast_prod[63:32];
  end
`endif

  m_unit_divider u_divider (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  // Shift-add multiply step, sign fix-up and result select for the final iteration
  always_comb begin
    add_sum   = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);
    prod_step = {add_sum, prod_q[31:1]};
    prod_fix  = res_neg_q ? (64'd0 - prod_step) : prod_step;
    quo_fix   = res_neg_q ? (32'd0 - div_quo) : div_quo;
    rem_fix   = a_neg_q ? (32'd0 - div_rem) : div_rem;
    iter_last = func3_q[2] ? div_done : (cnt_q == 6'd31);
    case (func3_q)
      M_MUL:                 final_res = prod_fix[31:0];
      M_MULH, M_MULHSU,
      M_MULHU:               final_res = prod_fix[63:32];
      M_DIV, M_DIVU:         final_res = quo_fix;
      default:               final_res = rem_fix;
    endcase
  end

  // FSM next state and output register inputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    func3_d   = func3_q;
    rd_d      = rd_q;
    wr_en_d   = wr_en_q;
    res_neg_d = res_neg_q;
    a_neg_d   = a_neg_q;
    mcand_d   = mcand_q;
    prod_d    = prod_q;
    result_d  = 32'd0;
    ready_d   = 1'b0;
    dest_d    = 5'd0;
    wr_d      = 1'b0;
    div_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          func3_d   = func3;
          rd_d      = rd;
          wr_en_d   = wr_en;
          a_neg_d   = a_neg;
          res_neg_d = a_neg ^ b_neg;
          mcand_d   = a_mag;
          prod_d    = {32'd0, b_mag};
          cnt_d     = 6'd0;
          if (special) begin
            state_d  = S_DONE;
            result_d = special_res;
            ready_d  = 1'b1;
            dest_d   = rd;
            wr_d     = wr_en;
          end
`ifdef M_UNIT_FAST_MUL_EN
          else if (!func3[2]) begin
            state_d  = S_DONE;
            result_d = fast_res;
            ready_d  = 1'b1;
            dest_d   = rd;
            wr_d     = wr_en;
          end
`endif
          else begin
            state_d   = S_ITER;
            div_start = func3[2];
          end
        end
      end
      S_ITER: begin
        cnt_d  = cnt_q + 6'd1;
        prod_d = prod_step;
        if (iter_last) begin
          state_d  = S_DONE;
          result_d = final_res;
          ready_d  = 1'b1;
          dest_d   = rd_q;
          wr_d     = wr_en_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State, operand and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 6'd0;
      func3_q   <= 3'd0;
      rd_q      <= 5'd0;
      wr_en_q   <= 1'b0;
      res_neg_q <= 1'b0;
      a_neg_q   <= 1'b0;
      mcand_q   <= 32'd0;
      prod_q    <= 64'd0;
      result_q  <= 32'd0;
      ready_q   <= 1'b0;
      dest_q    <= 5'd0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      func3_q   <= func3_d;
      rd_q      <= rd_d;
      wr_en_q   <= wr_en_d;
      res_neg_q <= res_neg_d;
      a_neg_q   <= a_neg_d;
      mcand_q   <= mcand_d;
      prod_q    <= prod_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
      dest_q    <= dest_d;
      wr_q      <= wr_d;
      busy_q    <= busy_d;
    end
  end

  assign m_unit_result = result_q;
  assign m_unit_ready  = ready_q;
  assign m_unit_dest   = dest_q;
  assign m_unit_wr     = wr_q;
  assign m_unit_busy   = busy_q;

endmodule

// File: tb/tb_m_unit.sv
// tb/tb_m_unit.sv - directed self-checking bench for m_unit
module tb_m_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_start = 1'b0;
  logic        pipeline_flush = 1'b0;
  logic [31:0] op1 = 32'd0;
  logic [31:0] op2 = 32'd0;
  logic [2:0]  func3 = 3'd0;
  logic [4:0]  rd = 5'd0;
  logic        wr_en = 1'b0;
  logic [31:0] m_unit_result;
  logic        m_unit_ready;
  logic [4:0]  m_unit_dest;
  logic        m_unit_wr;
  logic        m_unit_busy;

  int tests_run = 0;
  int tests_failed = 0;

`ifdef M_UNIT_FAST_MUL_EN
  localparam int MUL_CYC = 1;
`else
  localparam int MUL_CYC = 33;
`endif

  m_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .m_start        (m_start),
    .pipeline_flush (pipeline_flush),
    .op1            (op1),
    .op2            (op2),
    .func3          (func3),
    .rd             (rd),
    .wr_en          (wr_en),
    .m_unit_result  (m_unit_result),
    .m_unit_ready   (m_unit_ready),
    .m_unit_dest    (m_unit_dest),
    .m_unit_wr      (m_unit_wr),
    .m_unit_busy    (m_unit_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op, track ready/busy per cycle; optional flush and stray start mid-flight
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] r, input logic w,
                        input logic [31:0] exp, input int exp_cyc,
                        input int flush_cyc, input int restart_cyc);
    int got_cyc;
    int busy_cnt;
    logic [31:0] res;
    logic [4:0]  dst;
    logic        wv;
    got_cyc = 0; busy_cnt = 0; res = 32'd0; dst = 5'd0; wv = 1'b0;
    @(negedge clk);
    m_start = 1'b1; func3 = f; op1 = a; op2 = b; rd = r; wr_en = w;
    @(posedge clk); #1;
    m_start = 1'b0; op1 = ~a; op2 = 32'd0; rd = 5'd0; wr_en = ~w;
    for (int c = 1; c <= 40 && got_cyc == 0; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      pipeline_flush = (c == flush_cyc);
      if (c == restart_cyc) begin
        m_start = 1'b1; func3 = 3'b000; op1 = 32'd3; op2 = 32'd3; rd = 5'd9;
      end else begin
        m_start = 1'b0;
      end
      if (m_unit_busy) busy_cnt++;
      if (m_unit_ready) begin
        got_cyc = c; res = m_unit_result; dst = m_unit_dest; wv = m_unit_wr;
      end
    end
    pipeline_flush = 1'b0;
    m_start = 1'b0;
    check({tag, " ready_cycle"}, got_cyc, exp_cyc);
    check({tag, " result"}, res, exp);
    check({tag, " dest"}, {27'd0, dst}, {27'd0, r});
    check({tag, " wr"}, {31'd0, wv}, {31'd0, w});
    check({tag, " busy_cycles"}, busy_cnt, exp_cyc);
    @(posedge clk); #1;
    check({tag, " idle_after"}, {30'd0, m_unit_ready, m_unit_busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("reset outputs", {m_unit_result[30:0], m_unit_ready}, 32'd0);
    check("reset ctl", {25'd0, m_unit_dest, m_unit_wr, m_unit_busy}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    run_op("MUL",    3'b000, 32'h7,         32'hFFFF_FFFD, 5'd5,  1'b1, 32'hFFFF_FFEB, MUL_CYC, 0, 0);
    run_op("MULH",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  1'b1, 32'h4000_0000, MUL_CYC, 0, 0);
    run_op("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  1'b1, 32'hFFFF_FFFF, MUL_CYC, 0, 0);
    run_op("MULHU",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  1'b0, 32'hFFFF_FFFE, MUL_CYC, 0, 0);
    run_op("DIV",    3'b100, 32'hFFFF_FFF9, 32'h2,         5'd10, 1'b1, 32'hFFFF_FFFD, 33, 10, 0);
    run_op("REM",    3'b110, 32'hFFFF_FFF9, 32'h2,         5'd11, 1'b1, 32'hFFFF_FFFF, 33, 0, 5);
    run_op("DIVU",   3'b101, 32'h7,         32'h2,         5'd12, 1'b1, 32'h3,         33, 0, 0);
    run_op("REMU",   3'b111, 32'h7,         32'h2,         5'd13, 1'b1, 32'h1,         33, 0, 0);
    run_op("DIVneg", 3'b100, 32'h7,         32'hFFFF_FFFE, 5'd14, 1'b1, 32'hFFFF_FFFD, 33, 0, 0);
    run_op("REMneg", 3'b110, 32'h7,         32'hFFFF_FFFE, 5'd15, 1'b1, 32'h1,         33, 0, 0);
    run_op("DIVU0",  3'b101, 32'h1234,      32'h0,         5'd16, 1'b1, 32'hFFFF_FFFF, 1, 0, 0);
    run_op("REM0",   3'b110, 32'h1234,      32'h0,         5'd17, 1'b1, 32'h1234,      1, 0, 0);
    run_op("DIVovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 1'b1, 32'h8000_0000, 1, 0, 0);
    run_op("REMovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 1'b0, 32'h0,         1, 0, 0);

    // start together with flush is dropped
    @(negedge clk);
    m_start = 1'b1; pipeline_flush = 1'b1; func3 = 3'b101; op1 = 32'd9; op2 = 32'd0; rd = 5'd3; wr_en = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      check("flushed start", {30'd0, m_unit_ready, m_unit_busy}, 32'd0);
    end
    m_start = 1'b0; pipeline_flush = 1'b0;

    // reset in cycle 15 of a multiply
    @(negedge clk);
    m_start = 1'b1; func3 = 3'b000; op1 = 32'd5; op2 = 32'd6; rd = 5'd4; wr_en = 1'b1;
    @(posedge clk); #1;
    m_start = 1'b0;
    repeat (14) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("midrst outputs", {m_unit_result[30:0], m_unit_ready}, 32'd0);
    check("midrst ctl", {25'd0, m_unit_dest, m_unit_wr, m_unit_busy}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      check("post-rst quiet", {30'd0, m_unit_ready, m_unit_busy}, 32'd0);
    end
    run_op("DIVU after rst", 3'b101, 32'd100, 32'd7, 5'd21, 1'b1, 32'd14, 33, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
